// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encodings and sizing helpers for the iterative multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic int mult_cycles(input int n, input int k);
        return n / k;
    endfunction

    // Counter must hold the value CYCLES itself after the last RUN edge.
    function automatic int count_width(input int n, input int k);
        return $clog2(mult_cycles(n, k) + 1);
    endfunction

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - combinational partial-product accumulation of K multiplier bits
module mult_step #(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] mcand,
    input  logic [K-1:0]   mbits,
    output logic [2*N-1:0] acc_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < K; i++) begin
            if (mbits[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - multi-cycle shift-add multiplier with signed mode, early exit and abort
module iterative_multiplier
    import mult_pkg::*;
#(
    parameter int N              = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_EXIT     = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int K   = BITS_PER_CYCLE;
    localparam int CYC = mult_cycles(N, K);
    localparam int CW  = count_width(N, K);

    generate
        if (N % BITS_PER_CYCLE != 0) begin : g_bad_k
            $error("iterative_multiplier: BITS_PER_CYCLE must divide N");
        end
    endgenerate

    state_t         state;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mreg;
    logic [CW-1:0]  count;
    logic           neg;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;

    // Magnitudes are unsigned N-bit; -2^(N-1) negates to itself, which reads as 2^(N-1).
    always_comb begin
        mag_a = (signed_mode && multiplicand[N-1]) ? (~multiplicand + N'(1)) : multiplicand;
        mag_b = (signed_mode && multiplier[N-1])   ? (~multiplier + N'(1))   : multiplier;
    end

    assign busy = (state != ST_IDLE);

    mult_step #(.N(N), .K(K)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .mbits    (mreg[K-1:0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mreg    <= '0;
            count   <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand <= {{N{1'b0}}, mag_a};
                        mreg  <= mag_b;
                        neg   <= signed_mode & (multiplicand[N-1] ^ multiplier[N-1]);
                        acc   <= '0;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if ((EARLY_EXIT != 0) && (mreg == '0)) begin
                        state <= ST_FIX;
                    end else begin
                        acc   <= acc_next;
                        mreg  <= mreg >> K;
                        mcand <= mcand << K;
                        count <= count + 1'b1;
                        if (count == CW'(CYC - 1)) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        // Negating a zero accumulator wraps back to zero, so 0 * negative stays 0.
                        product <= neg ? (~acc + (2*N)'(1)) : acc;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// tb/tb_iterative_multiplier.sv - randomized and directed self-checking bench for iterative_multiplier
module tb_iterative_multiplier;

    localparam int KS[4]  = '{1, 2, 4, 1};
    localparam int EES[4] = '{0, 0, 0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [15:0] prod_v [4];

    int n_cmp = 0;
    int n_bad = 0;

    int          d_cnt   [4];
    int          d_time  [4][4];
    logic [15:0] d_prod  [4][4];
    int          b_cnt   [4];
    logic        busy_k  [4][64];

    always #5 clk = ~clk;

    iterative_multiplier #(.N(8), .BITS_PER_CYCLE(1), .EARLY_EXIT(0)) u_k1 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .multiplicand(a), .multiplier(b), .abort(abort),
        .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0]));
    iterative_multiplier #(.N(8), .BITS_PER_CYCLE(2), .EARLY_EXIT(0)) u_k2 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .multiplicand(a), .multiplier(b), .abort(abort),
        .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1]));
    iterative_multiplier #(.N(8), .BITS_PER_CYCLE(4), .EARLY_EXIT(0)) u_k4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .multiplicand(a), .multiplier(b), .abort(abort),
        .busy(busy_v[2]), .done(done_v[2]), .product(prod_v[2]));
    iterative_multiplier #(.N(8), .BITS_PER_CYCLE(1), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .multiplicand(a), .multiplier(b), .abort(abort),
        .busy(busy_v[3]), .done(done_v[3]), .product(prod_v[3]));

    function automatic logic [15:0] model_prod(input logic [7:0] x, input logic [7:0] y, input logic sm);
        longint xa;
        longint yb;
        longint p;
        xa = sm ? longint'($signed(x)) : longint'(x);
        yb = sm ? longint'($signed(y)) : longint'(y);
        p  = xa * yb;
        return p[15:0];
    endfunction

    // Edges from accept until done is seen.
    function automatic int model_lat(input logic [7:0] y, input logic sm, input int d);
        int mag;
        int bl;
        int steps;
        int cyc;
        mag = (sm && y[7]) ? 256 - int'(y) : int'(y);
        cyc = 8 / KS[d];
        if (EES[d] == 0) return cyc + 1;
        bl = 0;
        while ((mag >> bl) != 0) bl++;
        steps = (bl + KS[d] - 1) / KS[d];
        return ((steps < cyc) ? steps + 1 : cyc) + 1;
    endfunction

    task automatic sample(input int k);
        for (int d = 0; d < 4; d++) begin
            if (done_v[d]) begin
                if (d_cnt[d] < 4) begin
                    d_time[d][d_cnt[d]] = k;
                    d_prod[d][d_cnt[d]] = prod_v[d];
                end
                d_cnt[d]++;
            end
            if (busy_v[d]) b_cnt[d]++;
            busy_k[d][k] = busy_v[d];
        end
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic sm, input int n_cyc,
                          input int restart_at, input logic [7:0] rx, input logic [7:0] ry,
                          input int abort_at);
        for (int d = 0; d < 4; d++) begin
            d_cnt[d] = 0;
            b_cnt[d] = 0;
        end
        @(negedge clk);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sample(0);
        for (int k = 1; k <= n_cyc; k++) begin
            @(posedge clk);
            #1;
            sample(k);
            start = (k == restart_at);
            if (k == restart_at) begin
                a = rx;
                b = ry;
            end
            abort = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || prod_v[d] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b product=%h, want 0 0 0000", d, busy_v[d], done_v[d], prod_v[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        logic [7:0] xs[2] = '{8'd13, 8'd255};
        logic [7:0] ys[2] = '{8'd11, 8'd255};
        for (int t = 0; t < 2; t++) begin
            run_op(xs[t], ys[t], 1'b0, 20, -1, 8'd0, 8'd0, -1);
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (d_cnt[d] !== 1 || d_time[d][0] !== model_lat(ys[t], 1'b0, d) || b_cnt[d] !== model_lat(ys[t], 1'b0, d)) begin
                    n_bad++;
                    $display("FAIL unsigned_timing dut%0d op%0d: dones=%0d at=%0d busy=%0d, want 1 at %0d busy %0d",
                             d, t, d_cnt[d], d_time[d][0], b_cnt[d], model_lat(ys[t], 1'b0, d), model_lat(ys[t], 1'b0, d));
                end
                n_cmp++;
                if (d_prod[d][0] !== model_prod(xs[t], ys[t], 1'b0)) begin
                    n_bad++;
                    $display("FAIL unsigned_product dut%0d op%0d: got %h want %h", d, t, d_prod[d][0], model_prod(xs[t], ys[t], 1'b0));
                end
            end
        end
    endtask

    task automatic test_signed;
        logic [7:0] xs[4] = '{8'hFD, 8'h80, 8'h80, 8'h00};
        logic [7:0] ys[4] = '{8'h05, 8'h80, 8'h7F, 8'hF9};
        for (int t = 0; t < 4; t++) begin
            run_op(xs[t], ys[t], 1'b1, 20, -1, 8'd0, 8'd0, -1);
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (d_cnt[d] !== 1 || d_time[d][0] !== model_lat(ys[t], 1'b1, d)) begin
                    n_bad++;
                    $display("FAIL signed_timing dut%0d op%0d: dones=%0d at=%0d, want 1 at %0d",
                             d, t, d_cnt[d], d_time[d][0], model_lat(ys[t], 1'b1, d));
                end
                n_cmp++;
                if (d_prod[d][0] !== model_prod(xs[t], ys[t], 1'b1)) begin
                    n_bad++;
                    $display("FAIL signed_product dut%0d op%0d: got %h want %h", d, t, d_prod[d][0], model_prod(xs[t], ys[t], 1'b1));
                end
            end
        end
    endtask

    task automatic test_early_exit;
        logic [7:0] xs[3] = '{8'd77, 8'd200, 8'd3};
        logic [7:0] ys[3] = '{8'h00, 8'h01, 8'h80};
        int         want_ee[3] = '{2, 3, 9};
        for (int t = 0; t < 3; t++) begin
            run_op(xs[t], ys[t], 1'b0, 20, -1, 8'd0, 8'd0, -1);
            n_cmp++;
            if (d_cnt[3] !== 1 || d_time[3][0] !== want_ee[t] || d_prod[3][0] !== model_prod(xs[t], ys[t], 1'b0)) begin
                n_bad++;
                $display("FAIL early_exit op%0d: dones=%0d at=%0d product=%h, want 1 at %0d product %h",
                         t, d_cnt[3], d_time[3][0], d_prod[3][0], want_ee[t], model_prod(xs[t], ys[t], 1'b0));
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] x;
        logic [7:0] y;
        logic       sm;
        for (int t = 0; t < 16; t++) begin
            x  = 8'($urandom);
            y  = (t % 4 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            sm = 1'($urandom_range(0, 1));
            run_op(x, y, sm, 20, -1, 8'd0, 8'd0, -1);
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (d_cnt[d] !== 1 || d_time[d][0] !== model_lat(y, sm, d) || d_prod[d][0] !== model_prod(x, y, sm)) begin
                    n_bad++;
                    $display("FAIL random dut%0d %h*%h s=%b: dones=%0d at=%0d product=%h, want 1 at %0d product %h",
                             d, x, y, sm, d_cnt[d], d_time[d][0], d_prod[d][0], model_lat(y, sm, d), model_prod(x, y, sm));
                end
            end
        end
    endtask

    task automatic test_busy_ignore;
        run_op(8'd100, 8'd200, 1'b0, 20, 1, 8'd3, 8'd3, -1);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (d_cnt[d] !== 1 || d_prod[d][0] !== model_prod(8'd100, 8'd200, 1'b0) || prod_v[d] !== model_prod(8'd100, 8'd200, 1'b0)) begin
                n_bad++;
                $display("FAIL busy_ignore dut%0d: dones=%0d product=%h final=%h, want 1 product %h",
                         d, d_cnt[d], d_prod[d][0], prod_v[d], model_prod(8'd100, 8'd200, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat1;
        int lat2;
        run_op(8'hFD, 8'h05, 1'b1, 30, 9, 8'h81, 8'h7E, -1);
        for (int d = 0; d < 4; d++) begin
            lat1 = model_lat(8'h05, 1'b1, d);
            lat2 = model_lat(8'h7E, 1'b1, d);
            n_cmp++;
            if (d_cnt[d] !== 2 || d_time[d][0] !== lat1 || d_time[d][1] !== 10 + lat2) begin
                n_bad++;
                $display("FAIL back_to_back_timing dut%0d: dones=%0d at=%0d,%0d want 2 at %0d,%0d",
                         d, d_cnt[d], d_time[d][0], d_time[d][1], lat1, 10 + lat2);
            end
            n_cmp++;
            if (d_prod[d][0] !== model_prod(8'hFD, 8'h05, 1'b1) || d_prod[d][1] !== model_prod(8'h81, 8'h7E, 1'b1)) begin
                n_bad++;
                $display("FAIL back_to_back_product dut%0d: got %h,%h want %h,%h", d, d_prod[d][0], d_prod[d][1],
                         model_prod(8'hFD, 8'h05, 1'b1), model_prod(8'h81, 8'h7E, 1'b1));
            end
        end
    endtask

    task automatic test_abort;
        logic [15:0] old_p[4];
        for (int d = 0; d < 4; d++) old_p[d] = prod_v[d];
        run_op(8'h55, 8'hFF, 1'b0, 12, -1, 8'd0, 8'd0, 3);
        for (int d = 0; d < 4; d++) begin
            if (d == 2) begin
                n_cmp++;
                if (d_cnt[2] !== 1 || d_prod[2][0] !== model_prod(8'h55, 8'hFF, 1'b0)) begin
                    n_bad++;
                    $display("FAIL abort_idle_ignored dut2: dones=%0d product=%h want 1 product %h",
                             d_cnt[2], d_prod[2][0], model_prod(8'h55, 8'hFF, 1'b0));
                end
            end else begin
                n_cmp++;
                if (d_cnt[d] !== 0 || busy_k[d][3] !== 1'b1 || busy_k[d][4] !== 1'b0 || prod_v[d] !== old_p[d]) begin
                    n_bad++;
                    $display("FAIL abort dut%0d: dones=%0d busy3=%b busy4=%b product=%h, want 0 1 0 product %h",
                             d, d_cnt[d], busy_k[d][3], busy_k[d][4], prod_v[d], old_p[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a = 8'd200; b = 8'd77; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || prod_v[d] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_mid dut%0d: busy=%b done=%b product=%h, want 0 0 0000", d, busy_v[d], done_v[d], prod_v[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd6, 8'd7, 1'b0, 20, -1, 8'd0, 8'd0, -1);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (d_cnt[d] !== 1 || d_prod[d][0] !== 16'd42) begin
                n_bad++;
                $display("FAIL reset_recover dut%0d: dones=%0d product=%h, want 1 product 002a", d, d_cnt[d], d_prod[d][0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_early_exit();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
